evt_counter_multi: RTL and testbench

//  NUM_CH independent modulo event counters with per-channel runtime modulus, up/down

---
 rtl/evt_counter_multi.sv | 104 ++++++++++
 tb/tb_evt_counter_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_counter_multi.sv
// NUM_CH modulo event counters with runtime modulus, up/down, wrap/saturate and optional cascade.
// Latency: count_out/hit_out registered one cycle after the event; config takes effect on the accept edge.
module evt_counter_multi #(
  parameter  int NUM_CH      = 2,
  parameter  int WIDTH       = 11,
  parameter  int DEFAULT_MOD = 6,
  parameter  int CASCADE     = 0,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    clr_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       dir_in,
  input  logic [NUM_CH-1:0]       sat_in,
  input  logic                    cfg_valid_in,
  input  logic [CH_W-1:0]         cfg_ch_in,
  input  logic [WIDTH-1:0]        cfg_mod_in,
  output logic                    cfg_ready_out,
  output logic                    cfg_err_out,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       hit_out
);

  typedef logic [WIDTH-1:0] cnt_t;

  cnt_t              cnt_q   [NUM_CH];
  cnt_t              mod_q   [NUM_CH];
  cnt_t              cnt_d   [NUM_CH];
  cnt_t              mod_d   [NUM_CH];
  cnt_t              mod_m1  [NUM_CH];
  logic [NUM_CH-1:0] hit_q;
  logic [NUM_CH-1:0] hit_d;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] evt_eff;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] apply;
  logic              cfg_rdy_q;
  logic              cfg_err_q;
  logic              accept;
  logic              legal;

  always_comb begin
    accept = cfg_valid_in & cfg_rdy_q;
    legal  = (cfg_mod_in != '0) && (int'(cfg_ch_in) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      mod_d[i]   = mod_q[i];
      hit_d[i]   = 1'b0;
      wrap[i]    = 1'b0;
      apply[i]   = accept && legal && (int'(cfg_ch_in) == i);
      mod_m1[i]  = mod_q[i] - cnt_t'(1);
      term[i]    = dir_in[i] ? (cnt_q[i] == mod_m1[i]) : (cnt_q[i] == '0);
      // Cascade carry is the same-cycle wrap of the previous channel.
      if ((CASCADE != 0) && (i > 0)) evt_eff[i] = wrap[i-1];
      else                           evt_eff[i] = evt_in[i];

      if (apply[i]) mod_d[i] = cfg_mod_in;

      if (clr_in || apply[i]) begin
        cnt_d[i] = '0;
      end else if (evt_eff[i]) begin
        if (term[i]) begin
          hit_d[i] = 1'b1;
          if (!sat_in[i]) begin
            cnt_d[i] = dir_in[i] ? '0 : mod_m1[i];
            wrap[i]  = 1'b1;
          end
        end else begin
          cnt_d[i] = dir_in[i] ? (cnt_q[i] + cnt_t'(1)) : (cnt_q[i] - cnt_t'(1));
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        mod_q[i] <= cnt_t'(DEFAULT_MOD);
      end
      hit_q     <= '0;
      cfg_rdy_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        mod_q[i] <= mod_d[i];
      end
      hit_q     <= hit_d;
      cfg_rdy_q <= ~accept;
      cfg_err_q <= accept & ~legal;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign count_out[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign hit_out       = hit_q;
  assign cfg_ready_out = cfg_rdy_q;
  assign cfg_err_out   = cfg_err_q;

endmodule

// File: tb/tb_evt_counter_multi.sv
// Directed bench: dut_a is the default 2-channel build, dut_b a 3-channel cascaded build.
module tb_evt_counter_multi;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clr    = 1'b0;

  logic [1:0]  evt_a = '0, dir_a = '1, sat_a = '0;
  logic        cv_a = 1'b0;
  logic [0:0]  cch_a = '0;
  logic [10:0] cmod_a = '0;
  logic        rdy_a, err_a;
  logic [21:0] cnt_a;
  logic [1:0]  hit_a;

  logic [2:0]  evt_b = '0, dir_b = '1, sat_b = '0;
  logic        cv_b = 1'b0;
  logic [1:0]  cch_b = '0;
  logic [10:0] cmod_b = '0;
  logic        rdy_b, err_b;
  logic [32:0] cnt_b;
  logic [2:0]  hit_b;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  evt_counter_multi #(.NUM_CH(2), .WIDTH(11), .DEFAULT_MOD(6), .CASCADE(0)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n), .clr_in(clr),
    .evt_in(evt_a), .dir_in(dir_a), .sat_in(sat_a),
    .cfg_valid_in(cv_a), .cfg_ch_in(cch_a), .cfg_mod_in(cmod_a),
    .cfg_ready_out(rdy_a), .cfg_err_out(err_a),
    .count_out(cnt_a), .hit_out(hit_a));

  evt_counter_multi #(.NUM_CH(3), .WIDTH(11), .DEFAULT_MOD(6), .CASCADE(1)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n), .clr_in(clr),
    .evt_in(evt_b), .dir_in(dir_b), .sat_in(sat_b),
    .cfg_valid_in(cv_b), .cfg_ch_in(cch_b), .cfg_mod_in(cmod_b),
    .cfg_ready_out(rdy_b), .cfg_err_out(err_b),
    .count_out(cnt_b), .hit_out(hit_b));

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({cnt_a, hit_a, rdy_a, err_a} !== '0) begin
      bad++; $display("FAIL reset_a cnt=%h hit=%b rdy=%b err=%b want all 0", cnt_a, hit_a, rdy_a, err_a);
    end
    total++;
    if ({cnt_b, hit_b, rdy_b, err_b} !== '0) begin
      bad++; $display("FAIL reset_b cnt=%h hit=%b rdy=%b err=%b want all 0", cnt_b, hit_b, rdy_b, err_b);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    tick();
    total++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      bad++; $display("FAIL ready_after_reset got %b%b want 11", rdy_a, rdy_b);
    end
  endtask

  task automatic test_wrap();
    int hits = 0;
    evt_a = 2'b01; dir_a = 2'b11; sat_a = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (hit_a[0]) hits++;
      total++;
      if (cnt_a[10:0] !== 11'(k % 6) || hit_a[0] !== (k == 6) || cnt_a[21:11] !== 11'd0) begin
        bad++; $display("FAIL wrap k=%0d cnt0=%0d hit0=%b cnt1=%0d want %0d %b 0", k, cnt_a[10:0], hit_a[0], cnt_a[21:11], k % 6, k == 6);
      end
    end
    evt_a = 2'b00;
    tick();
    total++;
    if (hits != 1 || hit_a !== 2'b00) begin
      bad++; $display("FAIL wrap_hits count=%0d hit=%b want 1 00", hits, hit_a);
    end
  endtask

  task automatic test_cascade();
    cv_b = 1'b1; cch_b = 2'd0; cmod_b = 11'd4;
    tick();
    total++;
    if (rdy_b !== 1'b0) begin
      bad++; $display("FAIL casc_cfg_ready got %b want 0", rdy_b);
    end
    cch_b = 2'd1; cmod_b = 11'd3;
    tick();
    tick();
    cv_b = 1'b0;
    tick();
    evt_b = 3'b001; dir_b = 3'b111; sat_b = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (cnt_b[10:0] !== 11'(k % 4) || cnt_b[21:11] !== 11'((k / 4) % 3) ||
          hit_b[0] !== (k % 4 == 0) || hit_b[1] !== (k == 12)) begin
        bad++; $display("FAIL cascade k=%0d cnt0=%0d cnt1=%0d hit=%b want %0d %0d h0=%b h1=%b",
                        k, cnt_b[10:0], cnt_b[21:11], hit_b, k % 4, (k / 4) % 3, k % 4 == 0, k == 12);
      end
    end
    evt_b = 3'b000;
    total++;
    if (cnt_b[32:22] !== 11'd1) begin
      bad++; $display("FAIL cascade_ch2 got %0d want 1", cnt_b[32:22]);
    end
  endtask

  task automatic test_down_sat();
    evt_a = 2'b01; dir_a = 2'b10; sat_a = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (cnt_a[10:0] !== 11'd0 || hit_a[0] !== 1'b1) begin
        bad++; $display("FAIL down_sat k=%0d cnt0=%0d hit0=%b want 0 1", k, cnt_a[10:0], hit_a[0]);
      end
    end
    sat_a = 2'b00;
    tick();
    total++;
    if (cnt_a[10:0] !== 11'd5 || hit_a[0] !== 1'b1) begin
      bad++; $display("FAIL down_wrap cnt0=%0d hit0=%b want 5 1", cnt_a[10:0], hit_a[0]);
    end
    evt_a = 2'b00;
    tick();
    total++;
    if (cnt_a[10:0] !== 11'd5 || hit_a[0] !== 1'b0) begin
      bad++; $display("FAIL idle_hold cnt0=%0d hit0=%b want 5 0", cnt_a[10:0], hit_a[0]);
    end
  endtask

  task automatic test_cfg_evt();
    evt_a = 2'b10; dir_a = 2'b11;
    tick();
    tick();
    total++;
    if (cnt_a[21:11] !== 11'd2) begin
      bad++; $display("FAIL pre_cfg cnt1=%0d want 2", cnt_a[21:11]);
    end
    cv_a = 1'b1; cch_a = 1'b1; cmod_a = 11'd10;
    tick();
    cv_a = 1'b0;
    total++;
    if (cnt_a[21:11] !== 11'd0 || hit_a[1] !== 1'b0 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL cfg_apply cnt1=%0d hit1=%b rdy=%b want 0 0 0", cnt_a[21:11], hit_a[1], rdy_a);
    end
    for (int j = 1; j <= 10; j++) begin
      tick();
      total++;
      if (cnt_a[21:11] !== 11'(j % 10) || hit_a[1] !== (j == 10) || rdy_a !== 1'b1) begin
        bad++; $display("FAIL mod10 j=%0d cnt1=%0d hit1=%b rdy=%b want %0d %b 1", j, cnt_a[21:11], hit_a[1], rdy_a, j % 10, j == 10);
      end
    end
    evt_a = 2'b00;
    total++;
    if (cnt_a[10:0] !== 11'd5) begin
      bad++; $display("FAIL ch0_untouched cnt0=%0d want 5", cnt_a[10:0]);
    end
  endtask

  task automatic test_cfg_err();
    cv_a = 1'b1; cch_a = 1'b0; cmod_a = 11'd0;
    tick();
    cv_a = 1'b0;
    total++;
    if (err_a !== 1'b1 || rdy_a !== 1'b0) begin
      bad++; $display("FAIL err_mod0 err=%b rdy=%b want 1 0", err_a, rdy_a);
    end
    tick();
    total++;
    if (err_a !== 1'b0 || rdy_a !== 1'b1) begin
      bad++; $display("FAIL err_pulse err=%b rdy=%b want 0 1", err_a, rdy_a);
    end
    evt_a = 2'b01; dir_a = 2'b11;
    tick();
    evt_a = 2'b00;
    total++;
    if (cnt_a[10:0] !== 11'd0 || hit_a[0] !== 1'b1) begin
      bad++; $display("FAIL mod_kept cnt0=%0d hit0=%b want 0 1", cnt_a[10:0], hit_a[0]);
    end
    cv_b = 1'b1; cch_b = 2'd3; cmod_b = 11'd5;
    tick();
    cv_b = 1'b0;
    total++;
    if (err_b !== 1'b1 || rdy_b !== 1'b0 || cnt_b !== {11'd1, 11'd0, 11'd0}) begin
      bad++; $display("FAIL err_ch err=%b rdy=%b cnt=%h want 1 0 %h", err_b, rdy_b, cnt_b, {11'd1, 11'd0, 11'd0});
    end
    tick();
    total++;
    if (err_b !== 1'b0) begin
      bad++; $display("FAIL err_ch_pulse err=%b want 0", err_b);
    end
    // mod1 must still be 3: four ch0 events carry once, then two more carries wrap ch1.
    evt_b = 3'b001;
    for (int k = 0; k < 12; k++) tick();
    evt_b = 3'b000;
    total++;
    if (cnt_b[21:11] !== 11'd0 || cnt_b[32:22] !== 11'd2) begin
      bad++; $display("FAIL err_ch_mods cnt1=%0d cnt2=%0d want 0 2", cnt_b[21:11], cnt_b[32:22]);
    end
  endtask

  task automatic test_async_reset();
    evt_a = 2'b01; dir_a = 2'b11;
    tick();
    tick();
    evt_a = 2'b00;
    total++;
    if (cnt_a[10:0] !== 11'd2) begin
      bad++; $display("FAIL pre_rst cnt0=%0d want 2", cnt_a[10:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cnt_a !== '0 || hit_a !== '0 || rdy_a !== 1'b0 || cnt_b !== '0) begin
      bad++; $display("FAIL async_rst cnt_a=%h hit=%b rdy=%b cnt_b=%h want 0", cnt_a, hit_a, rdy_a, cnt_b);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    tick();
    total++;
    if (rdy_a !== 1'b1) begin
      bad++; $display("FAIL rst_release rdy=%b want 1", rdy_a);
    end
  endtask

  task automatic test_clr();
    evt_a = 2'b11; dir_a = 2'b11; sat_a = 2'b00;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (cnt_a !== {11'd5, 11'd5}) begin
      bad++; $display("FAIL pre_clr cnt=%h want %h", cnt_a, {11'd5, 11'd5});
    end
    clr = 1'b1; cv_a = 1'b1; cch_a = 1'b0; cmod_a = 11'd2;
    tick();
    clr = 1'b0; cv_a = 1'b0;
    total++;
    if (cnt_a !== '0 || hit_a !== 2'b00) begin
      bad++; $display("FAIL clr cnt=%h hit=%b want 0 00", cnt_a, hit_a);
    end
    evt_a = 2'b01;
    tick();
    total++;
    if (cnt_a[10:0] !== 11'd1 || hit_a[0] !== 1'b0) begin
      bad++; $display("FAIL clr_cfg1 cnt0=%0d hit0=%b want 1 0", cnt_a[10:0], hit_a[0]);
    end
    tick();
    evt_a = 2'b00;
    total++;
    if (cnt_a[10:0] !== 11'd0 || hit_a[0] !== 1'b1) begin
      bad++; $display("FAIL clr_cfg2 cnt0=%0d hit0=%b want 0 1", cnt_a[10:0], hit_a[0]);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_cascade();
    test_down_sat();
    test_cfg_evt();
    test_cfg_err();
    test_async_reset();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
